// File: rtl/bcd_display_sched.sv
// Shared binary-to-BCD converter for the score display: arbitrates two requesters
// and runs a WIDTH-cycle shift-add-3 conversion, holding the digits between updates.

module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);
    assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;
endmodule

module bcd_display_sched #(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_a,
    input  logic [WIDTH-1:0]      val_a,
    input  logic                  req_b,
    input  logic [WIDTH-1:0]      val_b,
    output logic                  ack_a,
    output logic                  ack_b,
    output logic                  busy,
    output logic                  done,
    output logic                  valid,
    output logic                  src,
    output logic [4*DIGITS-1:0]   digits
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_sreg;
    logic [BW-1:0]    r_bcd;
    logic [BW-1:0]    w_adj;
    logic [CW-1:0]    r_count;
    logic             r_last;     // 1 = B was granted last
    logic             r_gnt_id;
    logic             r_ack_a, r_ack_b, r_done, r_valid, r_src;
    logic [BW-1:0]    r_digits;
    logic             w_take;
    logic             w_gnt_b;
    logic             w_unused_carry;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            bcd_add3 u_add3 (
                .i_nib (r_bcd[4*g +: 4]),
                .o_nib (w_adj[4*g +: 4])
            );
        end
    endgenerate

    // The adjusted top bit is shifted out; valid parameters keep it zero.
    assign w_unused_carry = w_adj[BW-1];

    // On a tie, B wins only if A was served last.
    assign w_gnt_b = req_b & (~req_a | ~r_last);

    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_a || req_b) begin
                    w_next = S_CONV;
                    w_take = 1'b1;
                end
            end
            S_CONV: begin
                if (r_count == CW'(1)) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sreg   <= '0;
            r_bcd    <= '0;
            r_count  <= '0;
            r_last   <= 1'b1;
            r_gnt_id <= 1'b0;
            r_ack_a  <= 1'b0;
            r_ack_b  <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
            r_src    <= 1'b0;
            r_digits <= '0;
        end else begin
            r_ack_a <= w_take & ~w_gnt_b;
            r_ack_b <= w_take & w_gnt_b;
            r_done  <= (r_state == S_DONE);
            if (w_take) begin
                r_sreg   <= w_gnt_b ? val_b : val_a;
                r_bcd    <= '0;
                r_count  <= CW'(WIDTH);
                r_gnt_id <= w_gnt_b;
                r_last   <= w_gnt_b;
            end
            if (r_state == S_CONV) begin
                {r_bcd, r_sreg} <= {w_adj[BW-2:0], r_sreg, 1'b0};
                r_count         <= r_count - CW'(1);
            end
            if (r_state == S_DONE) begin
                r_digits <= r_bcd;
                r_src    <= r_gnt_id;
                r_valid  <= 1'b1;
            end
        end
    end

    assign ack_a  = r_ack_a;
    assign ack_b  = r_ack_b;
    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign valid  = r_valid;
    assign src    = r_src;
    assign digits = r_digits;
endmodule
